// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and the FIFO pointer/flag
// controller. The master side issues push/pop requests; the slave side
// (fifo_ctrl) returns row selects, occupancy and status flags.
interface fifo_ctrl_if #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
);
   logic             wr_en;
   logic             rd_en;
   logic [DEPTH-1:0] ws;
   logic [DEPTH-1:0] rs;
   logic [DEPTH-1:0] oe;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr_en, rd_en,
      input  ws, rs, oe, full, empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  wr_en, rd_en,
      output ws, rs, oe, full, empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a register-file FIFO whose rows share a
// tri-state read bus. Decides which row captures on a push and which row
// drives the bus (first-word-fall-through), and tracks occupancy and misuse.
module fifo_ctrl #(
   parameter int DEPTH    = 8,
   parameter int PTR_W    = 3,
   parameter int AF_LEVEL = 6
) (
   input logic          clk,
   input logic          clear,
   fifo_ctrl_if.slave   bus
);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_AF    = (PTR_W+1)'(AF_LEVEL);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic [PTR_W:0]   count_next;
   logic             full_reg;
   logic             empty_reg;
   logic             af_reg;
   logic             overflow_reg;
   logic             underflow_reg;

   logic             push_ok;
   logic             pop_ok;
   logic [DEPTH-1:0] ws_vec;
   logic [DEPTH-1:0] rs_vec;

   // Request acceptance. A push into a full FIFO is allowed when a pop frees
   // the head row in the same cycle; clear suppresses both.
   always_comb begin
      push_ok = !clear && bus.wr_en && (!full_reg || bus.rd_en);
      pop_ok  = !clear && bus.rd_en && !empty_reg;
   end

   // One-hot row decoders: write-select follows the write pointer only on an
   // accepted push; the head row drives the bus whenever data is present.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_sel
         assign ws_vec[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
         assign rs_vec[gi] = !empty_reg && (rd_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   assign bus.ws          = ws_vec;
   assign bus.rs          = rs_vec;
   assign bus.oe          = rs_vec;
   assign bus.full        = full_reg;
   assign bus.empty       = empty_reg;
   assign bus.almost_full = af_reg;
   assign bus.count       = count_reg;
   assign bus.overflow    = overflow_reg;
   assign bus.underflow   = underflow_reg;

   // Next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok)
         count_next = count_reg + CNT_ONE;
      else if (pop_ok && !push_ok)
         count_next = count_reg - CNT_ONE;
   end

   // Pointers, occupancy and flags; flags derive from the next count so they
   // always agree with the registered count.
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         af_reg        <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         count_reg <= count_next;
         full_reg  <= (count_next == CNT_DEPTH);
         empty_reg <= (count_next == '0);
         af_reg    <= (count_next >= CNT_AF);
         if (bus.wr_en && !push_ok)
            overflow_reg <= 1'b1;
         if (bus.rd_en && !pop_ok)
            underflow_reg <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios followed by biased
// random push/pop/clear traffic, compared every cycle against a queue model
// that records which row each stored word was written to.
module tb_fifo_ctrl;
   localparam int DEPTH    = 8;
   localparam int PTR_W    = 3;
   localparam int AF_LEVEL = 6;

   logic clk = 1'b0;
   logic clear;

   fifo_ctrl_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

   fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .AF_LEVEL(AF_LEVEL)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: queue of row numbers holding stored words (head first), next row
   // to be written, and sticky error flags.
   int q[$];
   int wr_row;
   bit m_ovf;
   bit m_unf;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DEPTH-1:0] onehot(input int row);
      logic [DEPTH-1:0] v;
      v = '0;
      v[row] = 1'b1;
      return v;
   endfunction

   // One clock cycle: drive requests, check outputs against the model before
   // the edge, then advance the model for the coming edge.
   task automatic do_cycle(input bit w, input bit r, input bit c);
      logic [DEPTH-1:0] exp_ws;
      logic [DEPTH-1:0] exp_oe;
      bit push;
      bit pop;
      int n;
      @(negedge clk);
      bus.wr_en = w;
      bus.rd_en = r;
      clear     = c;
      #1;
      n    = q.size();
      push = !c && w && (n < DEPTH || r);
      pop  = !c && r && (n > 0);
      exp_ws = push ? onehot(wr_row) : '0;
      exp_oe = (n > 0) ? onehot(q[0]) : '0;
      check_val("ws", 32'(bus.ws), 32'(exp_ws));
      check_val("rs", 32'(bus.rs), 32'(exp_oe));
      check_val("oe", 32'(bus.oe), 32'(exp_oe));
      check_val("count", 32'(bus.count), 32'(n));
      check_val("full", 32'(bus.full), 32'(n == DEPTH));
      check_val("empty", 32'(bus.empty), 32'(n == 0));
      check_val("almost_full", 32'(bus.almost_full), 32'(n >= AF_LEVEL));
      check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
      check_val("underflow", 32'(bus.underflow), 32'(m_unf));
      $display("cycle wr=%0b rd=%0b clr=%0b ws=%02h oe=%02h count=%0d ovf=%0b unf=%0b",
               w, r, c, bus.ws, bus.oe, bus.count, bus.overflow, bus.underflow);
      if (c) begin
         q.delete();
         wr_row = 0;
         m_ovf  = 0;
         m_unf  = 0;
      end else begin
         if (w && !push) m_ovf = 1;
         if (r && !pop)  m_unf = 1;
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(wr_row);
            wr_row = (wr_row + 1) % DEPTH;
         end
      end
   endtask

   initial begin
      int pw;
      int pr;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      clear     = 1'b1;
      repeat (2) @(posedge clk);
      q.delete();
      wr_row = 0;
      m_ovf  = 0;
      m_unf  = 0;

      // Reset then idle
      repeat (5) do_cycle(0, 0, 0);
      // Fill with one extra push to hit overflow
      repeat (DEPTH + 1) do_cycle(1, 0, 0);
      // Drain with one extra pop to hit underflow
      repeat (DEPTH + 1) do_cycle(0, 1, 0);
      do_cycle(0, 0, 1);
      // Wrap: push 5, pop 5, push 6
      repeat (5) do_cycle(1, 0, 0);
      repeat (5) do_cycle(0, 1, 0);
      repeat (6) do_cycle(1, 0, 0);
      // Simultaneous at full
      repeat (2) do_cycle(1, 0, 0);
      repeat (3) do_cycle(1, 1, 0);
      do_cycle(0, 0, 0);
      // Simultaneous at empty
      do_cycle(0, 0, 1);
      do_cycle(1, 1, 0);
      do_cycle(0, 0, 0);
      // Mid-operation clear with count 4
      do_cycle(0, 0, 1);
      repeat (4) do_cycle(1, 0, 0);
      do_cycle(1, 1, 1);
      do_cycle(0, 0, 0);

      // Biased random traffic
      for (int blk = 0; blk < 12; blk++) begin
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 150; i++)
            do_cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 199) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the register-file FIFO: drives the per-row write-select, read-select and output-enable lines of a stack of DEPTH 5-bit storage rows whose tri-state outputs share one read bus. It accepts push/pop requests, keeps the read and write pointers, occupancy and status flags, and records misuse. The storage rows capture data and drive the bus; this block decides which row does each.

## Interface
- DEPTH, 8: number of storage rows; power of two, 2 to 64.
- PTR_W, 3: pointer width, log2(DEPTH).
- AF_LEVEL, 6: `almost_full` threshold, 1 to DEPTH-1.

- clk  in  1  clock; all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- wr_en  in  1  push request this cycle.
- rd_en  in  1  pop request this cycle.
- ws  out  DEPTH  one-hot row write-select; combinational.
- rs  out  DEPTH  one-hot row read-select; combinational.
- oe  out  DEPTH  one-hot row output-enable onto the shared bus; combinational.
- full  out  1  count == DEPTH; registered.
- empty  out  1  count == 0; registered.
- almost_full  out  1  count >= AF_LEVEL; registered.
- count  out  PTR_W+1  occupancy, 0..DEPTH; registered.
- overflow  out  1  sticky: push refused.
- underflow  out  1  sticky: pop refused.

## Operation
- State: wr_ptr, rd_ptr (PTR_W bits, wrap DEPTH-1 -> 0 naturally), count (PTR_W+1 bits), overflow, underflow.
- Push accepted (`push_ok`) = wr_en & (!full | rd_en).
- Pop accepted (`pop_ok`) = rd_en & !empty.
- ws = push_ok ? one-hot(wr_ptr) : 0. Selected row captures its DataIn at the coming edge.
- rs = oe = empty ? 0 : one-hot(rd_ptr). First-word-fall-through: head word is on the bus whenever not empty, independent of rd_en; pop advances the pointer.
- At most one bit set in each of ws, rs, oe in any cycle; oe all-zero leaves the bus high-Z.
- Edge updates: push_ok -> wr_ptr+1; pop_ok -> rd_ptr+1; count += push_ok - pop_ok (both -> unchanged).
- full, empty, almost_full recomputed from the next count, so registered flags match count every cycle.
- Full & wr_en & rd_en: both accepted; the head row is read this cycle and rewritten at the edge (wr_ptr == rd_ptr); count stays DEPTH.
- Empty & wr_en & rd_en: push accepted, pop refused, underflow set; count -> 1.
- Full & wr_en & !rd_en: push refused, ws = 0, overflow set.
- Empty & rd_en & !wr_en: pop refused, underflow set.
- overflow/underflow stay set until clear.

## Timing
- clear high at an edge: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_full = 0, overflow = underflow = 0. Because empty = 1, rs = oe = 0 the cycle after. ws is still a function of wr_en that cycle.
- While clear is high, push_ok and pop_ok are forced to 0, so ws = 0. Clear takes priority over any simultaneous push or pop, and a clear asserted mid-stream discards contents.
- Write latency: a word pushed at edge N is on the bus from cycle N+1 if the FIFO was empty, where empty falls at edge N.
- Pop: the word popped in cycle N is valid on the bus during cycle N. The next head word, or high-Z if the FIFO becomes empty, is on the bus from edge N.
- Sustained push+pop every cycle gives throughput of one word per cycle with no bubbles.
- Flags change only at edges. No combinational path from wr_en or rd_en to full, empty, count or the error flags.

## Test plan
- Reset then idle: after clear, count = 0, empty = 1, full = 0, ws = rs = oe = 0, error flags 0. Hold 5 cycles with no requests: nothing changes.
- Fill: 8 consecutive pushes. ws walks 0x01, 0x02 … 0x80. almost_full rises after the 6th edge, full after the 8th, count = 8. A 9th push gives ws = 0 and overflow = 1, count stays 8.
- Drain: from full, 8 pops. oe walks 0x01 … 0x80, then 0x00. empty rises after the 8th edge. A 9th pop sets underflow = 1, count stays 0.
- Wrap: push 5, pop 5, then push 6. ws sequence includes 0x20, 0x40, 0x80, 0x01, 0x02, 0x04; oe = 0x20 after the first push of the second batch; count = 6.
- Simultaneous: at full, push+pop gives count 8 and ws == oe == one-hot(rd_ptr), with no overflow. At empty, push+pop gives count 1, underflow = 1, and oe = 0x01 next cycle.
- Mid-operation clear: with count 4 and wr_en = rd_en = 1, assert clear. In that cycle ws = 0; after the edge count = 0, pointers are 0, flags are at reset values and oe = 0.
